// File: rtl/reaction_ctrl_if.sv
// Bundle of the reaction-time sequencer's control inputs and status outputs.
// The master side (player/stimulus logic) drives start, key and rand_num;
// the slave side (reaction_ctrl) drives the state code and measurement results.
interface reaction_ctrl_if;
  logic        start;
  logic        key;
  logic [13:0] rand_num;
  logic [2:0]  machine_state;
  logic        led;
  logic [13:0] react_ms;
  logic        timeout;
  logic        result_valid;
  logic [13:0] best_ms;

  modport master (
    output start, key, rand_num,
    input  machine_state, led, react_ms, timeout, result_valid, best_ms
  );

  modport slave (
    input  start, key, rand_num,
    output machine_state, led, react_ms, timeout, result_valid, best_ms
  );
endinterface

// File: rtl/reaction_ctrl.sv
// Main sequencer for the reaction-time tester.
//
//   state  | meaning
//   IDLE   | waiting for the first start pulse
//   WAIT   | capturing the random delay, then counting it down in ms
//   ACTIVE | LED lit, measuring the player's response
//   RESULT | measurement latched, waiting for the next start
//   FOUL   | key pressed before the LED lit, waiting for the next start
//
// WAIT timing: rand_num is captured on the third WAIT edge. The ms count then
// runs, and ACTIVE is entered one edge after ms_cnt reaches delay_ms, i.e.
// 4 + delay_ms*CLK_PER_MS cycles after WAIT entry (the +1 is compare latency).
module reaction_ctrl #(
  parameter int CLK_PER_MS = 50000,
  parameter int MAX_MS     = 9999
) (
  input  logic            clk,
  input  logic            rst,
  reaction_ctrl_if.slave  bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_ACTIVE = 3'd2;
  localparam logic [2:0] S_RESULT = 3'd3;
  localparam logic [2:0] S_FOUL   = 3'd4;

  localparam int          PW      = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_PER_MS - 1);
  localparam logic [PW-1:0] PRE_ONE = PW'(1);
  localparam logic [13:0] MAX14   = 14'(MAX_MS);

  logic [2:0]    state;
  logic [PW-1:0] prescaler;
  logic [13:0]   ms_cnt;
  logic [1:0]    wait_cyc;
  logic [13:0]   delay_ms;
  logic [13:0]   react_ms;
  logic          timeout;
  logic          result_valid;
  logic [13:0]   best_ms;

  logic tick;
  assign tick = (prescaler == PRE_MAX);

  // Sequencer state, ms timebase, delay capture and result bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      prescaler    <= '0;
      ms_cnt       <= '0;
      wait_cyc     <= '0;
      delay_ms     <= 14'd1000;
      react_ms     <= '0;
      timeout      <= 1'b0;
      result_valid <= 1'b0;
      best_ms      <= MAX14;
    end else begin
      result_valid <= 1'b0;
      case (state)
        S_IDLE, S_RESULT, S_FOUL: begin
          // start has priority here; key is ignored outside WAIT/ACTIVE
          if (bus.start) begin
            state     <= S_WAIT;
            prescaler <= '0;
            ms_cnt    <= '0;
            wait_cyc  <= '0;
          end
        end
        S_WAIT: begin
          if (bus.key) begin
            state     <= S_FOUL;
            prescaler <= '0;
            ms_cnt    <= '0;
          end else if (wait_cyc != 2'd3) begin
            // generator output is settled by the third WAIT cycle
            wait_cyc <= wait_cyc + 2'd1;
            if (wait_cyc == 2'd2) delay_ms <= bus.rand_num;
          end else if (ms_cnt == delay_ms) begin
            state     <= S_ACTIVE;
            prescaler <= '0;
            ms_cnt    <= '0;
          end else if (tick) begin
            prescaler <= '0;
            ms_cnt    <= ms_cnt + 14'd1;
          end else begin
            prescaler <= prescaler + PRE_ONE;
          end
        end
        S_ACTIVE: begin
          if (bus.key) begin
            state        <= S_RESULT;
            prescaler    <= '0;
            ms_cnt       <= '0;
            react_ms     <= ms_cnt;
            timeout      <= 1'b0;
            result_valid <= 1'b1;
            if (ms_cnt < best_ms) best_ms <= ms_cnt;
          end else if (ms_cnt == MAX14) begin
            state        <= S_RESULT;
            prescaler    <= '0;
            ms_cnt       <= '0;
            react_ms     <= MAX14;
            timeout      <= 1'b1;
            result_valid <= 1'b1;
          end else if (tick) begin
            prescaler <= '0;
            ms_cnt    <= ms_cnt + 14'd1;
          end else begin
            prescaler <= prescaler + PRE_ONE;
          end
        end
        default: begin
          state     <= S_IDLE;
          prescaler <= '0;
          ms_cnt    <= '0;
        end
      endcase
    end
  end

  assign bus.machine_state = state;
  assign bus.led           = (state == S_ACTIVE);
  assign bus.react_ms      = react_ms;
  assign bus.timeout       = timeout;
  assign bus.result_valid  = result_valid;
  assign bus.best_ms       = best_ms;

endmodule

// File: tb/tb_reaction_ctrl.sv
// Directed sequence with randomized delays and response times, checked against
// a trial-level model: latency = 3 + delay*CLK_PER_MS (+-1), reaction = elapsed
// cycles / CLK_PER_MS truncated, best = minimum of non-timeout reactions.
module tb_reaction_ctrl;
  localparam int CPM   = 4;
  localparam int MAXMS = 9999;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  int   best_ref  = MAXMS;
  int   react_ref = 0;
  int   to_ref    = 0;

  reaction_ctrl_if bus();

  reaction_ctrl #(.CLK_PER_MS(CPM), .MAX_MS(MAXMS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_results(input string tag);
    chk({tag, "_react"},   32'(bus.react_ms), 32'(react_ref));
    chk({tag, "_timeout"}, 32'(bus.timeout),  32'(to_ref));
    chk({tag, "_best"},    32'(bus.best_ms),  32'(best_ref));
  endtask

  // Called at the negedge right after the WAIT entry edge.
  task automatic wait_active(input int d);
    int cnt = 0;
    bit done = 0;
    while (!done && cnt <= CPM*d + 20) begin
      @(negedge clk);
      cnt++;
      if (cnt == 2) begin
        chk("wait_state", 32'(bus.machine_state), 32'd1);
        chk("wait_led", 32'(bus.led), 32'd0);
        bus.rand_num = 14'(d);
      end
      if (bus.machine_state == 3'd2) done = 1;
    end
    chk("active_reached", 32'(done), 32'd1);
    chk("active_latency_window",
        32'((cnt >= 3 + CPM*d - 1) && (cnt <= 3 + CPM*d + 1)), 32'd1);
    chk("active_led", 32'(bus.led), 32'd1);
  endtask

  task automatic start_trial(input int d);
    bus.rand_num = 14'd9000;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("start_to_wait", 32'(bus.machine_state), 32'd1);
    wait_active(d);
  endtask

  // Key sampled on edge A+m where A is the ACTIVE entry edge.
  task automatic respond(input int m, input bit with_start);
    int exp_r;
    repeat (m - 1) @(negedge clk);
    bus.key = 1'b1;
    if (with_start) bus.start = 1'b1;
    @(negedge clk);
    bus.key = 1'b0;
    bus.start = 1'b0;
    exp_r = (m - 1) / CPM;
    react_ref = exp_r;
    to_ref = 0;
    if (exp_r < best_ref) best_ref = exp_r;
    chk("result_state", 32'(bus.machine_state), 32'd3);
    chk("result_valid_hi", 32'(bus.result_valid), 32'd1);
    chk("result_led", 32'(bus.led), 32'd0);
    chk_results("result");
    @(negedge clk);
    chk("result_valid_lo", 32'(bus.result_valid), 32'd0);
    chk("result_hold", 32'(bus.machine_state), 32'd3);
  endtask

  initial begin
    int d;
    int m;
    int cnt;
    int ms_list [3] = '{300, 150, 200};
    bus.start = 1'b0;
    bus.key = 1'b0;
    bus.rand_num = 14'd1000;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(bus.machine_state), 32'd0);
    chk("rst_led", 32'(bus.led), 32'd0);
    chk("rst_rv", 32'(bus.result_valid), 32'd0);
    chk_results("rst");
    rst = 1'b0;
    @(negedge clk);

    // key ignored in IDLE
    bus.key = 1'b1;
    @(negedge clk);
    bus.key = 1'b0;
    chk("idle_key_ignored", 32'(bus.machine_state), 32'd0);

    // normal trial: delay 1000 ms, key 20 ms after LED
    start_trial(1000);
    respond(20*CPM + 1, 1'b0);

    // foul on the second WAIT cycle
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("foul_wait", 32'(bus.machine_state), 32'd1);
    @(negedge clk);
    bus.key = 1'b1;
    @(negedge clk);
    bus.key = 1'b0;
    chk("foul_state", 32'(bus.machine_state), 32'd4);
    chk("foul_led", 32'(bus.led), 32'd0);
    chk_results("foul");
    repeat (5) @(negedge clk);
    chk("foul_hold", 32'(bus.machine_state), 32'd4);
    chk("foul_rv", 32'(bus.result_valid), 32'd0);

    // timeout trial, started from FOUL
    d = $urandom_range(1000, 1010);
    start_trial(d);
    cnt = 0;
    while (bus.machine_state == 3'd2 && cnt <= CPM*MAXMS + 10) begin
      @(negedge clk);
      cnt++;
    end
    react_ref = MAXMS;
    to_ref = 1;
    chk("timeout_latency", 32'(cnt), 32'(CPM*MAXMS + 1));
    chk("timeout_state", 32'(bus.machine_state), 32'd3);
    chk("timeout_rv", 32'(bus.result_valid), 32'd1);
    chk_results("timeout");
    @(negedge clk);
    chk("timeout_rv_lo", 32'(bus.result_valid), 32'd0);

    // asynchronous reset in the middle of ACTIVE
    d = $urandom_range(1000, 1010);
    start_trial(d);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    best_ref = MAXMS;
    react_ref = 0;
    to_ref = 0;
    chk("arst_state", 32'(bus.machine_state), 32'd0);
    chk("arst_led", 32'(bus.led), 32'd0);
    chk("arst_rv", 32'(bus.result_valid), 32'd0);
    chk_results("arst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_idle", 32'(bus.machine_state), 32'd0);

    // best tracking over three trials
    for (int i = 0; i < 3; i++) begin
      d = $urandom_range(1000, 1010);
      start_trial(d);
      respond(ms_list[i]*CPM + 1 + $urandom_range(0, CPM-1), 1'b0);
    end

    // key and start together in ACTIVE: key wins
    d = $urandom_range(1000, 1010);
    start_trial(d);
    respond($urandom_range(1, 1600), 1'b1);

    // key and start together in RESULT: start wins
    bus.rand_num = 14'd9000;
    bus.key = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.key = 1'b0;
    bus.start = 1'b0;
    chk("result_simul_wait", 32'(bus.machine_state), 32'd1);
    chk("result_simul_rv", 32'(bus.result_valid), 32'd0);
    chk_results("result_simul");
    d = $urandom_range(1000, 1010);
    wait_active(d);
    respond($urandom_range(1, 1600), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/reaction_ctrl.md
# reaction_ctrl

Main sequencer for the reaction-time tester. Owns `machine_state`, which drives the random-delay generator and the display logic. It captures a 1000–9999 ms random delay, lights the stimulus LED when the delay expires, and measures the player's response in milliseconds. It also detects early presses (foul) and keeps the best valid time since reset.

## Interface

Parameters:
- CLK_PER_MS, 50000: clock cycles per millisecond (50 MHz system clock).
- MAX_MS, 9999: reaction-time ceiling in ms; also the timeout value.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  debounced single-cycle pulse that starts a trial.
- key  input  1  debounced single-cycle pulse for the player response.
- rand_num  input  14  random delay in ms from the random generator, range 1000–9999.
- machine_state  output  3  state code: IDLE=0, WAIT=1, ACTIVE=2, RESULT=3, FOUL=4.
- led  output  1  stimulus LED; high only in ACTIVE.
- react_ms  output  14  last measured reaction time in ms.
- timeout  output  1  high when the last trial hit MAX_MS without a key press.
- result_valid  output  1  one-cycle pulse on entry to RESULT.
- best_ms  output  14  minimum non-timeout react_ms since reset.

## Operation

- Reset values:
  - machine_state=IDLE, led=0, react_ms=0, timeout=0, result_valid=0, best_ms=MAX_MS.
  - Internal state: prescaler=0, ms_cnt=0, wait_cyc=0, delay_ms=1000.
- State transitions:
  - IDLE: start → WAIT. key is ignored.
  - WAIT, delay capture: wait_cyc counts clocks since entry and saturates at 3. When wait_cyc==2, delay_ms <= rand_num, because the generator output is stable from the third WAIT cycle onward.
  - WAIT, counting: ms_cnt counts ms ticks only after capture (wait_cyc==3). When ms_cnt==delay_ms, go to ACTIVE.
  - WAIT, early press: key in any WAIT cycle, including capture cycles → FOUL.
  - ACTIVE: led=1 and ms_cnt counts ms ticks from 0.
    - key → RESULT, with react_ms <= ms_cnt and timeout <= 0.
    - If ms_cnt reaches MAX_MS with no key → RESULT, with react_ms <= MAX_MS and timeout <= 1.
  - RESULT: on entry, result_valid pulses for 1 cycle. If timeout==0 and react_ms < best_ms, best_ms is updated on the same edge. start → WAIT.
  - FOUL: react_ms and best_ms are unchanged. start → WAIT.
- Prescaler and ms_cnt:
  - Both clear on every state entry, so each ms count starts exactly at entry.
  - A tick fires when prescaler==CLK_PER_MS-1; prescaler then wraps to 0.
- Simultaneous key and start: key wins in WAIT/ACTIVE; start wins in IDLE/RESULT/FOUL, where key is ignored.
- Widths: ms_cnt and delay_ms are 14-bit. ms_cnt never exceeds MAX_MS (9999 < 16384), so there is no wrap.
- Any rst assertion, including mid-trial, returns all registers immediately to their reset values. best_ms is lost.

## Timing

- Every transition takes effect on the clock edge after the qualifying input or count condition. Outputs are registered.
- start sampled in IDLE at edge N: machine_state=WAIT after edge N.
- WAIT delay: ACTIVE is entered exactly 3 + delay_ms·CLK_PER_MS cycles after WAIT entry, give or take one cycle of compare latency. The implementation must document which; the bench checks within ±1 cycle.
- led follows machine_state with no extra latency.
- react_ms resolution is 1 ms, truncated: a key press within the first ms after ACTIVE entry yields 0.
- result_valid is high in exactly the first RESULT cycle. best_ms updates on that same edge.

## Test plan

Run with CLK_PER_MS=4.

- Reset mid-ACTIVE: assert rst asynchronously → all outputs return to reset values without a clock edge; machine_state=0, best_ms=9999.
- Normal trial: rand_num held at 1000, start, key 20 ms after led rises → ACTIVE entered about 4003 cycles after WAIT; RESULT with react_ms=20, timeout=0, best_ms=20, single result_valid pulse.
- Foul: key on the second WAIT cycle → FOUL, led never rises, react_ms and best_ms unchanged; start → WAIT.
- Timeout: no key in ACTIVE → RESULT after 9999 ms, react_ms=9999, timeout=1, best_ms unchanged.
- Best tracking: trials of 300, 150, then 200 ms → best_ms reads 300, then 150, then stays 150.
- Simultaneous events:
  - key and start in the same ACTIVE cycle → RESULT; start is ignored.
  - key and start in the same RESULT cycle → WAIT.
